// File: rtl/otg_hpi_pio_gen2_if.sv
// -----------------------------------------------------------------------------
// otg_hpi_pio_gen2_if
//   Avalon-MM slave bus (s1) between the Nios II data master and the
//   HPI/OTG PIO block.
//
//   address     3-bit word address          (master -> slave)
//   chipselect  slave select                (master -> slave)
//   write_n     write strobe, active low    (master -> slave)
//   writedata   32-bit write data           (master -> slave)
//   readdata    32-bit read data            (slave  -> master)
// -----------------------------------------------------------------------------
interface otg_hpi_pio_gen2_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/otg_hpi_pio_gen2.sv
// -----------------------------------------------------------------------------
// otg_hpi_pio_gen2
//   Parametrised PIO for the HPI/OTG pins: per-bit direction with output
//   enables, input synchroniser, atomic set/clear of the output register and
//   edge capture feeding a maskable level interrupt.
//
//   Ports
//     clk        system clock
//     reset_n    synchronous active-low reset
//     s1         Avalon-MM slave bus (see otg_hpi_pio_gen2_if)
//     in_port    asynchronous pin inputs
//     out_port   pin output values (data_out register)
//     oe         per-bit output enable (direction register, 1 = drive)
//     irq        level interrupt, |(edge_cap & irq_mask)
//
//   Register map (word address)
//     0 DATA      wr: data_out = wd      rd: dir ? data_out : sync
//     1 DIR       rd/wr
//     2 IRQ_MASK  rd/wr
//     3 EDGE_CAP  rd; wr: write-1-to-clear
//     4 OUTSET    wr: data_out |= wd     rd: 0
//     5 OUTCLR    wr: data_out &= ~wd    rd: 0
//     6,7         rd 0, writes ignored
// -----------------------------------------------------------------------------
module otg_hpi_pio_gen2 #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    EDGE_TYPE   = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    otg_hpi_pio_gen2_if.slave         s1,
    input  logic [DATA_WIDTH-1:0]     in_port,
    output logic [DATA_WIDTH-1:0]     out_port,
    output logic [DATA_WIDTH-1:0]     oe,
    output logic                      irq
);

    // The priming counter stops at SYNC_STAGES+1: by then the synchroniser
    // and prev register hold real pin samples, so the first edge term that
    // can reach edge_cap compares two genuine samples rather than the reset
    // zeros. Width is sized so the terminal value always fits.
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_EDGE   = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] dir_q,      dir_d;
    logic [DATA_WIDTH-1:0] mask_q,     mask_d;
    logic [DATA_WIDTH-1:0] cap_q,      cap_d;
    logic [PRIME_W-1:0]    prime_q,    prime_d;
    logic [31:0]           readdata_q, readdata_d;

    logic [DATA_WIDTH-1:0] sync_w;
    logic [DATA_WIDTH-1:0] edge_w;
    logic [DATA_WIDTH-1:0] wd_w;
    logic                  wr_en;
    logic                  primed;
    logic                  unused_wd;

    assign wr_en     = s1.chipselect & ~s1.write_n;
    assign wd_w      = s1.writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^s1.writedata;
    assign sync_w    = sync_q[SYNC_STAGES-1];
    assign primed    = (prime_q == PRIME_W'(PRIME_MAX));

    always_comb begin
        edge_w = sync_w ^ prev_q;
        if (EDGE_TYPE == 0) begin
            edge_w = sync_w & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_w = ~sync_w & prev_q;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        cap_d      = cap_q;
        prime_d    = primed ? prime_q : prime_q + PRIME_W'(1);

        if (wr_en) begin
            case (s1.address)
                A_DATA:   data_out_d = wd_w;
                A_DIR:    dir_d      = wd_w;
                A_MASK:   mask_d     = wd_w;
                A_EDGE:   cap_d      = cap_q & ~wd_w;
                A_OUTSET: data_out_d = data_out_q | wd_w;
                A_OUTCLR: data_out_d = data_out_q & ~wd_w;
                default:  ;
            endcase
        end

        // Applied after the W1C so a fresh edge on a bit being cleared wins.
        if (primed) begin
            cap_d = cap_d | edge_w;
        end
    end

    always_comb begin
        readdata_d = '0;
        case (s1.address)
            A_DATA:  readdata_d = 32'((dir_q & data_out_q) | (~dir_q & sync_w));
            A_DIR:   readdata_d = 32'(dir_q);
            A_MASK:  readdata_d = 32'(mask_q);
            A_EDGE:  readdata_d = 32'(cap_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            data_out_q <= RESET_OUT;
            dir_q      <= RESET_DIR;
            mask_q     <= '0;
            cap_q      <= '0;
            prime_q    <= '0;
            readdata_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q     <= sync_w;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            prime_q    <= prime_d;
            readdata_q <= readdata_d;
        end
    end

    assign s1.readdata = readdata_q;
    assign out_port    = data_out_q;
    assign oe          = dir_q;
    assign irq         = |(cap_q & mask_q);

endmodule
